dmem_arbiter: RTL



---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the 64-bit data memory.
// Port A is the CPU memory stage, port B the loader/debug port.
module dmem_arbiter #(
  parameter int DATA_WID = 64,
  parameter int MEM_TOP  = 96
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [DATA_WID-1:0] a_addr,
  input  logic [DATA_WID-1:0] a_wdata,
  output logic                a_ack,
  output logic [DATA_WID-1:0] a_rdata,
  output logic                a_err,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [DATA_WID-1:0] b_addr,
  input  logic [DATA_WID-1:0] b_wdata,
  output logic                b_ack,
  output logic [DATA_WID-1:0] b_rdata,
  output logic                b_err,
  output logic [DATA_WID-1:0] mem_addr,
  output logic [DATA_WID-1:0] mem_wdata,
  output logic                mem_write,
  output logic                mem_read,
  input  logic [DATA_WID-1:0] mem_rdata,
  output logic                busy
);

  localparam logic [DATA_WID-1:0] LIM =
    DATA_WID'(MEM_TOP - 7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                gnt_b_q, gnt_b_d;
  logic                last_b_q, last_b_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [DATA_WID-1:0] maddr_q, maddr_d;
  logic [DATA_WID-1:0] mwdata_q, mwdata_d;
  logic                mwr_q, mwr_d;
  logic                mrd_q, mrd_d;
  logic                a_ack_q, a_ack_d;
  logic                a_err_q, a_err_d;
  logic [DATA_WID-1:0] a_rd_q, a_rd_d;
  logic                b_ack_q, b_ack_d;
  logic                b_err_q, b_err_d;
  logic [DATA_WID-1:0] b_rd_q, b_rd_d;
  logic                busy_q, busy_d;

  logic                pick_b;
  logic                sel_we;
  logic                sel_err;
  logic [DATA_WID-1:0] sel_addr;
  logic [DATA_WID-1:0] sel_wdata;
  logic [DATA_WID-1:0] rd_val;

  // Grant selection, access sequencing and registered outputs.
  always_comb begin
    state_d  = state_q;
    gnt_b_d  = gnt_b_q;
    last_b_d = last_b_q;
    we_d     = we_q;
    err_d    = err_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwr_d    = mwr_q;
    mrd_d    = mrd_q;
    a_ack_d  = a_ack_q;
    a_err_d  = a_err_q;
    a_rd_d   = a_rd_q;
    b_ack_d  = b_ack_q;
    b_err_d  = b_err_q;
    b_rd_d   = b_rd_q;
    busy_d   = busy_q;

    pick_b    = b_req & (~a_req | ~last_b_q);
    sel_we    = pick_b ? b_we : a_we;
    sel_addr  = pick_b ? b_addr : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    sel_err   = sel_addr > LIM;
    rd_val    = (~we_q & ~err_q) ? mem_rdata : '0;

    unique case (state_q)
      S_IDLE: begin
        if (a_req | b_req) begin
          state_d  = S_ACCESS;
          gnt_b_d  = pick_b;
          we_d     = sel_we;
          err_d    = sel_err;
          maddr_d  = sel_addr;
          mwdata_d = sel_wdata;
          mwr_d    = sel_we & ~sel_err;
          mrd_d    = ~sel_we & ~sel_err;
          busy_d   = 1'b1;
        end
      end
      S_ACCESS: begin
        state_d  = S_DONE;
        mwr_d    = 1'b0;
        mrd_d    = 1'b0;
        last_b_d = gnt_b_q;
        if (gnt_b_q) begin
          b_ack_d = 1'b1;
          b_err_d = err_q;
          b_rd_d  = rd_val;
        end else begin
          a_ack_d = 1'b1;
          a_err_d = err_q;
          a_rd_d  = rd_val;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        a_ack_d = 1'b0;
        a_err_d = 1'b0;
        b_ack_d = 1'b0;
        b_err_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      gnt_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwr_q    <= 1'b0;
      mrd_q    <= 1'b0;
      a_ack_q  <= 1'b0;
      a_err_q  <= 1'b0;
      a_rd_q   <= '0;
      b_ack_q  <= 1'b0;
      b_err_q  <= 1'b0;
      b_rd_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_b_q  <= gnt_b_d;
      last_b_q <= last_b_d;
      we_q     <= we_d;
      err_q    <= err_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwr_q    <= mwr_d;
      mrd_q    <= mrd_d;
      a_ack_q  <= a_ack_d;
      a_err_q  <= a_err_d;
      a_rd_q   <= a_rd_d;
      b_ack_q  <= b_ack_d;
      b_err_q  <= b_err_d;
      b_rd_q   <= b_rd_d;
      busy_q   <= busy_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign a_err     = a_err_q;
  assign a_rdata   = a_rd_q;
  assign b_ack     = b_ack_q;
  assign b_err     = b_err_q;
  assign b_rdata   = b_rd_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign mem_write = mwr_q;
  assign mem_read  = mrd_q;
  assign busy      = busy_q;

endmodule
